// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types and defaults for the audio output path
package audio_pkg;

    localparam int AUDIO_DATA_W = 16;

    typedef enum logic [1:0] {
        S_WAIT    = 2'd0,
        S_ACK     = 2'd1,
        S_RELEASE = 2'd2
    } hs_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - 2-FF synchronizer with registered-history rising-edge pulse
module sync_edge_det #(
    parameter logic HIST_RST = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic rise_o
);

    logic       s1_q;
    logic       s2_q;
    logic       hist_q;
    logic [1:0] warm_q;

    // History keeps its reset value until s2 carries a real input sample,
    // so a level already high when reset releases never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            hist_q <= HIST_RST;
            warm_q <= 2'b00;
        end else begin
            s1_q   <= async_i;
            s2_q   <= s1_q;
            warm_q <= {warm_q[0], 1'b1};
            hist_q <= warm_q[1] ? s2_q : hist_q;
        end
    end

    assign rise_o = s2_q & ~hist_q;

endmodule

// File: rtl/sample_pacer.sv
// rtl/sample_pacer.sv - single-entry sample buffer released on sample-rate ticks
module sample_pacer
    import audio_pkg::*;
#(
    parameter int DATA_W     = AUDIO_DATA_W,
    parameter int GAIN_SHIFT = 0,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sample_tick,
    input  logic [DATA_W-1:0] passdata,
    input  logic              sample_valid,
    output logic              confirm_reciv,
    output logic [DATA_W-1:0] audio_out,
    output logic              audio_strobe,
    output logic [CNT_W-1:0]  underrun_cnt
);

    hs_state_t                state_q, state_d;
    logic [DATA_W-1:0]        pending_q, pending_d;
    logic                     pending_valid_q, pending_valid_d;
    logic                     confirm_q, confirm_d;
    logic [DATA_W-1:0]        audio_q, audio_d;
    logic                     strobe_q, strobe_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     tick_rise;
    logic signed [DATA_W-1:0] scaled;

    sync_edge_det #(.HIST_RST(1'b1)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .async_i (sample_tick),
        .rise_o  (tick_rise)
    );

    assign scaled = $signed(pending_q) >>> GAIN_SHIFT;

    always_comb begin
        state_d         = state_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        confirm_d       = 1'b0;
        audio_d         = audio_q;
        strobe_d        = 1'b0;
        cnt_d           = cnt_q;

        case (state_q)
            S_WAIT: begin
                if (sample_valid && !pending_valid_q) begin
                    pending_d       = passdata;
                    pending_valid_d = 1'b1;
                    confirm_d       = 1'b1;
                    state_d         = S_ACK;
                end
            end
            S_ACK:     state_d = S_RELEASE;
            S_RELEASE: if (!sample_valid) state_d = S_WAIT;
            default:   state_d = S_WAIT;
        endcase

        // Capture needs an empty buffer and consumption needs a full one,
        // so these two updates of pending_valid never collide.
        if (tick_rise && en) begin
            strobe_d = 1'b1;
            if (pending_valid_q) begin
                audio_d         = scaled;
                pending_valid_d = 1'b0;
            end else if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_WAIT;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            confirm_q       <= 1'b0;
            audio_q         <= '0;
            strobe_q        <= 1'b0;
            cnt_q           <= '0;
        end else begin
            state_q         <= state_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            confirm_q       <= confirm_d;
            audio_q         <= audio_d;
            strobe_q        <= strobe_d;
            cnt_q           <= cnt_d;
        end
    end

    assign confirm_reciv = confirm_q;
    assign audio_out     = audio_q;
    assign audio_strobe  = strobe_q;
    assign underrun_cnt  = cnt_q;

endmodule

// File: tb/tb_sample_pacer.sv
// tb/tb_sample_pacer.sv - scoreboard bench for sample_pacer (gain 0 and gain 2 / 2-bit counter)
module tb_sample_pacer;

    logic        clk = 1'b0;
    logic        rst, en, sample_tick, sample_valid;
    logic [15:0] passdata;
    logic        conf0, strb0, conf1, strb1;
    logic [15:0] aud0, aud1;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    always #5 clk = ~clk;

    sample_pacer u0 (
        .clk(clk), .rst(rst), .en(en), .sample_tick(sample_tick),
        .passdata(passdata), .sample_valid(sample_valid),
        .confirm_reciv(conf0), .audio_out(aud0), .audio_strobe(strb0),
        .underrun_cnt(cnt0)
    );

    sample_pacer #(.DATA_W(16), .GAIN_SHIFT(2), .CNT_W(2)) u1 (
        .clk(clk), .rst(rst), .en(en), .sample_tick(sample_tick),
        .passdata(passdata), .sample_valid(sample_valid),
        .confirm_reciv(conf1), .audio_out(aud1), .audio_strobe(strb1),
        .underrun_cnt(cnt1)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          conf_cnt0 = 0;
    int          conf_cnt1 = 0;
    int          strb_cnt0 = 0;
    int          exp_conf = 0;
    logic [15:0] q0[$];
    logic [15:0] q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (conf0) conf_cnt0++;
        if (conf1) conf_cnt1++;
        if (strb0) begin
            strb_cnt0++;
            if (q0.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL strobe0_unexpected: got audio %0h expected no strobe", aud0);
            end else begin
                chk("audio0", {16'h0, aud0}, {16'h0, q0.pop_front()});
            end
        end
        if (strb1) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL strobe1_unexpected: got audio %0h expected no strobe", aud1);
            end else begin
                chk("audio1", {16'h0, aud1}, {16'h0, q1.pop_front()});
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Tick high 4 cycles, low 4; the strobe must appear 3 edges after the rise.
    task automatic tick(input logic strobe_exp, input logic [15:0] e0, input logic [15:0] e1);
        if (strobe_exp) begin
            q0.push_back(e0);
            q1.push_back(e1);
        end
        sample_tick = 1'b1;
        cyc(3);
        chk("strobe_latency", {31'h0, strb0}, {31'h0, strobe_exp});
        cyc(1);
        sample_tick = 1'b0;
        cyc(4);
    endtask

    task automatic send(input logic [15:0] d);
        int waited;
        waited = 0;
        passdata     = d;
        sample_valid = 1'b1;
        exp_conf++;
        do begin
            cyc(1);
            waited++;
        end while (!conf0 && waited < 10);
        chk("confirm_seen", {31'h0, conf0}, 32'h1);
        sample_valid = 1'b0;
        cyc(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int s;
        rst = 1'b1; en = 1'b1; sample_tick = 1'b0; sample_valid = 1'b0; passdata = 16'h0;
        cyc(2);
        chk("rst_audio0", {16'h0, aud0}, 32'h0);
        chk("rst_strobe0", {31'h0, strb0}, 32'h0);
        chk("rst_confirm0", {31'h0, conf0}, 32'h0);
        chk("rst_cnt0", {16'h0, cnt0}, 32'h0);
        chk("rst_cnt1", {30'h0, cnt1}, 32'h0);
        rst = 1'b0;
        cyc(3);

        // Underrun and saturation of the 2-bit counter
        repeat (3) tick(1'b1, 16'h0000, 16'h0000);
        chk("under_cnt0", {16'h0, cnt0}, 32'd3);
        chk("under_cnt1", {30'h0, cnt1}, 32'd3);
        repeat (2) tick(1'b1, 16'h0000, 16'h0000);
        chk("sat_cnt0", {16'h0, cnt0}, 32'd5);
        chk("sat_cnt1", {30'h0, cnt1}, 32'd3);

        // Basic flow and gain
        send(16'h1234);
        chk("basic_confirms", conf_cnt0, exp_conf);
        tick(1'b1, 16'h1234, 16'h048D);
        chk("basic_cnt0", {16'h0, cnt0}, 32'd5);
        send(16'h8000);
        tick(1'b1, 16'h8000, 16'hE000);

        // Hold guard: one capture despite 20 cycles of held valid
        fork
            begin
                passdata = 16'hAAAA;
                sample_valid = 1'b1;
                cyc(20);
                sample_valid = 1'b0;
            end
            begin
                repeat (3) tick(1'b1, 16'hAAAA, 16'hEAAA);
            end
        join
        exp_conf++;
        chk("hold_confirms", conf_cnt0, exp_conf);
        chk("hold_cnt0", {16'h0, cnt0}, 32'd7);
        send(16'h5555);
        tick(1'b1, 16'h5555, 16'h1555);
        chk("rerise_confirms", conf_cnt0, exp_conf);

        // Capture lands on the same edge as the tick: underrun, sample stays pending
        fork
            tick(1'b1, 16'h5555, 16'h1555);
            begin
                cyc(2);
                passdata = 16'h3C3C;
                sample_valid = 1'b1;
                cyc(3);
                sample_valid = 1'b0;
            end
        join
        exp_conf++;
        chk("collide_cnt0", {16'h0, cnt0}, 32'd8);
        tick(1'b1, 16'h3C3C, 16'h0F0F);
        chk("collide_after_cnt0", {16'h0, cnt0}, 32'd8);

        // Paused playback still prefills
        en = 1'b0;
        send(16'h1111);
        tick(1'b0, 16'h0, 16'h0);
        tick(1'b0, 16'h0, 16'h0);
        chk("pause_cnt0", {16'h0, cnt0}, 32'd8);
        en = 1'b1;
        tick(1'b1, 16'h1111, 16'h0444);
        chk("resume_cnt0", {16'h0, cnt0}, 32'd8);

        // Reset in S_RELEASE with pending full and tick high, valid still held
        passdata = 16'h0F0F;
        sample_valid = 1'b1;
        exp_conf++;
        cyc(2);
        sample_tick = 1'b1;
        rst = 1'b1;
        cyc(1);
        chk("mid_rst_audio0", {16'h0, aud0}, 32'h0);
        chk("mid_rst_audio1", {16'h0, aud1}, 32'h0);
        chk("mid_rst_strobe0", {31'h0, strb0}, 32'h0);
        chk("mid_rst_confirm0", {31'h0, conf0}, 32'h0);
        chk("mid_rst_cnt0", {16'h0, cnt0}, 32'h0);
        chk("mid_rst_cnt1", {30'h0, cnt1}, 32'h0);
        s = strb_cnt0;
        rst = 1'b0;
        exp_conf++;
        cyc(12);
        chk("post_rst_strobes", strb_cnt0, s);
        chk("recapture_confirms", conf_cnt0, exp_conf);
        sample_valid = 1'b0;
        sample_tick = 1'b0;
        cyc(4);
        tick(1'b1, 16'h0F0F, 16'h03C3);
        chk("post_rst_cnt0", {16'h0, cnt0}, 32'h0);
        chk("post_rst_cnt1", {30'h0, cnt1}, 32'h0);

        cyc(4);
        chk("q0_drained", q0.size(), 32'h0);
        chk("q1_drained", q1.size(), 32'h0);
        chk("confirms1", conf_cnt1, exp_conf);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
